// File: rtl/debug_controller.sv
// Debug sequencer between the UART pair and the MIPS pipeline: loads a program
// byte-wise into instruction memory, runs or single-steps it, then dumps PC and registers.
module debug_controller #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_ADDR   = 7,
  parameter int                 NB_REG    = 5,
  parameter int                 N_BITS    = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_BITS-1:0]  rx_data,
  input  logic               rx_done,
  output logic [N_BITS-1:0]  tx_data,
  output logic               tx_start,
  input  logic               tx_done,
  output logic               mem_we,
  output logic [NB_ADDR-1:0] mem_addr,
  output logic [NB_DATA-1:0] mem_wdata,
  output logic               pc_clear,
  output logic               en_pipeline,
  input  logic               halt_i,
  input  logic [NB_ADDR-1:0] pc_i,
  output logic [NB_REG-1:0]  dbg_reg_addr,
  input  logic [NB_DATA-1:0] dbg_reg_data,
  output logic               busy,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WRITE     = 3'd2,
    S_RUN       = 3'd3,
    S_STEP      = 3'd4,
    S_DUMP_PC   = 3'd5,
    S_DUMP_REG  = 3'd6,
    S_DUMP_WAIT = 3'd7
  } state_t;

  localparam logic [N_BITS-1:0]  CMD_LOAD  = N_BITS'(1);
  localparam logic [N_BITS-1:0]  CMD_RUN   = N_BITS'(2);
  localparam logic [N_BITS-1:0]  CMD_STEP  = N_BITS'(3);
  localparam logic [NB_ADDR-1:0] ADDR_LAST = {NB_ADDR{1'b1}};
  localparam logic [NB_REG-1:0]  REG_LAST  = {NB_REG{1'b1}};

  state_t               state_q;
  logic [1:0]           byte_cnt_q;
  logic [NB_ADDR-1:0]   word_addr_q;
  logic [NB_DATA-1:0]   shift_q;
  logic [NB_DATA-1:0]   hold_q;
  logic [1:0]           byte_sel_q;
  logic                 pc_phase_q;
  logic [N_BITS-1:0]    tx_data_q;
  logic                 tx_start_q;
  logic                 mem_we_q;
  logic [NB_ADDR-1:0]   mem_addr_q;
  logic [NB_DATA-1:0]   mem_wdata_q;
  logic                 pc_clear_q;
  logic                 en_q;
  logic [NB_REG-1:0]    dbg_addr_q;

  function automatic logic [N_BITS-1:0] byte_of(input logic [NB_DATA-1:0] w,
                                                input logic [1:0]         sel);
    case (sel)
      2'd3:    byte_of = w[4*N_BITS-1 -: N_BITS];
      2'd2:    byte_of = w[3*N_BITS-1 -: N_BITS];
      2'd1:    byte_of = w[2*N_BITS-1 -: N_BITS];
      default: byte_of = w[N_BITS-1 -: N_BITS];
    endcase
  endfunction

  // Single sequencing FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= 2'd0;
      word_addr_q <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      byte_sel_q  <= 2'd0;
      pc_phase_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pc_clear_q  <= 1'b0;
      en_q        <= 1'b0;
      dbg_addr_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      mem_we_q   <= 1'b0;
      pc_clear_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_done) begin
            case (rx_data)
              CMD_LOAD: begin
                pc_clear_q  <= 1'b1;
                word_addr_q <= '0;
                byte_cnt_q  <= 2'd0;
                state_q     <= S_LOAD;
              end
              CMD_RUN: begin
                // Enable is raised on the entry edge so a pipeline already
                // halted still sees exactly one enable cycle.
                en_q    <= 1'b1;
                state_q <= S_RUN;
              end
              CMD_STEP: begin
                en_q    <= 1'b1;
                state_q <= S_STEP;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
        S_LOAD: begin
          if (rx_done) begin
            shift_q <= {shift_q[NB_DATA-N_BITS-1:0], rx_data};
            if (byte_cnt_q == 2'd3) begin
              byte_cnt_q  <= 2'd0;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_addr_q;
              mem_wdata_q <= {shift_q[NB_DATA-N_BITS-1:0], rx_data};
              state_q     <= S_WRITE;
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end
        S_WRITE: begin
          if ((shift_q == HALT_WORD) || (word_addr_q == ADDR_LAST)) begin
            state_q <= S_IDLE;
          end else begin
            word_addr_q <= word_addr_q + NB_ADDR'(1);
            state_q     <= S_LOAD;
          end
        end
        S_RUN: begin
          if (halt_i) begin
            en_q    <= 1'b0;
            state_q <= S_DUMP_PC;
          end else begin
            en_q <= 1'b1;
          end
        end
        S_STEP: begin
          en_q    <= 1'b0;
          state_q <= S_DUMP_PC;
        end
        S_DUMP_PC: begin
          tx_data_q  <= N_BITS'(pc_i);
          tx_start_q <= 1'b1;
          pc_phase_q <= 1'b1;
          state_q    <= S_DUMP_WAIT;
        end
        S_DUMP_REG: begin
          // Register value is captured on its first byte so later bytes stay coherent.
          if (byte_sel_q == 2'd3) begin
            hold_q    <= dbg_reg_data;
            tx_data_q <= byte_of(dbg_reg_data, 2'd3);
          end else begin
            tx_data_q <= byte_of(hold_q, byte_sel_q);
          end
          tx_start_q <= 1'b1;
          state_q    <= S_DUMP_WAIT;
        end
        S_DUMP_WAIT: begin
          if (tx_done) begin
            if (pc_phase_q) begin
              pc_phase_q <= 1'b0;
              dbg_addr_q <= '0;
              byte_sel_q <= 2'd3;
              state_q    <= S_DUMP_REG;
            end else if (byte_sel_q != 2'd0) begin
              byte_sel_q <= byte_sel_q - 2'd1;
              state_q    <= S_DUMP_REG;
            end else if (dbg_addr_q == REG_LAST) begin
              dbg_addr_q <= '0;
              state_q    <= S_IDLE;
            end else begin
              dbg_addr_q <= dbg_addr_q + NB_REG'(1);
              byte_sel_q <= 2'd3;
              state_q    <= S_DUMP_REG;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign pc_clear     = pc_clear_q;
  assign en_pipeline  = en_q;
  assign dbg_reg_addr = dbg_addr_q;
  assign busy         = (state_q != S_IDLE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_debug_controller.sv
// Directed self-checking bench for debug_controller with a small TX UART
// responder and a combinational register bank (reg[i] = i * 0x01010101).
module tb_debug_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        pc_clear;
  logic        en_pipeline;
  logic        halt_i = 1'b0;
  logic [6:0]  pc_i = 7'd0;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_data;
  logic        busy;
  logic [2:0]  state_o;

  int checks = 0;
  int failures = 0;

  int          n_pcclr, n_wr, n_en, n_excl, n_early, n_unstable;
  logic [6:0]  wr_addr [0:255];
  logic [31:0] wr_data [0:255];
  logic [7:0]  tx_q [$];
  logic        tx_busy = 1'b0;
  int          tx_cnt = 0;
  logic [7:0]  tx_hold = 8'h00;
  logic [59:0] outs;

  debug_controller dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pc_clear(pc_clear), .en_pipeline(en_pipeline), .halt_i(halt_i), .pc_i(pc_i),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
    .busy(busy), .state_o(state_o)
  );

  always #5 clock = ~clock;

  assign dbg_reg_data = {4{3'b000, dbg_reg_addr}};
  assign outs = {tx_data, tx_start, mem_we, mem_addr, mem_wdata, pc_clear,
                 en_pipeline, dbg_reg_addr, busy, state_o};

  // Observe outputs and act as the TX UART (tx_done three cycles after tx_start).
  always @(negedge clock) begin
    tx_done = 1'b0;
    if (!reset) begin
      tx_busy = 1'b0;
      tx_cnt  = 0;
    end else begin
      if (pc_clear) n_pcclr++;
      if (en_pipeline) n_en++;
      if (mem_we) begin
        if (n_wr < 256) begin
          wr_addr[n_wr] = mem_addr;
          wr_data[n_wr] = mem_wdata;
        end
        n_wr++;
      end
      if ((int'(mem_we) + int'(en_pipeline) + int'(tx_start)) > 1) n_excl++;
      if (tx_start) begin
        if (tx_busy) n_early++;
        tx_q.push_back(tx_data);
        tx_hold = tx_data;
        tx_busy = 1'b1;
        tx_cnt  = 3;
      end else if (tx_busy) begin
        if (tx_data !== tx_hold) n_unstable++;
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_done = 1'b1;
          tx_busy = 1'b0;
        end
      end
    end
  end

  task automatic clr_mon();
    n_pcclr = 0; n_wr = 0; n_en = 0; n_excl = 0; n_early = 0; n_unstable = 0;
    tx_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock); rx_data = b; rx_done = 1'b1;
    @(negedge clock); rx_done = 1'b0;
    @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8]);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (state_o !== 3'd0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (state_o !== 3'd0) begin
      failures++;
      $display("FAIL %s_timeout: state_o=%0d, required 0 within %0d cycles", name, state_o, budget);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_dump(input string name, input logic [7:0] pc_exp);
    check_int({name, "_tx_count"}, tx_q.size(), 129);
    if (tx_q.size() == 129) begin
      checks++;
      if (tx_q[0] !== pc_exp) begin
        failures++;
        $display("FAIL %s_pc_byte: got %02h, expected %02h", name, tx_q[0], pc_exp);
      end
      for (int r = 0; r < 32; r++) begin
        for (int b = 0; b < 4; b++) begin
          checks++;
          if (tx_q[1 + 4*r + b] !== r[7:0]) begin
            failures++;
            $display("FAIL %s_reg%0d_byte%0d: got %02h, expected %02h", name, r, b,
                     tx_q[1 + 4*r + b], r[7:0]);
          end
        end
      end
    end
    check_int({name, "_tx_early"}, n_early, 0);
    check_int({name, "_tx_unstable"}, n_unstable, 0);
    check_int({name, "_exclusive"}, n_excl, 0);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (outs !== 60'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, expected 0", outs);
    end
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || state_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b state=%0d, expected busy=0 state=0", busy, state_o);
    end
  endtask

  task automatic test_load_basic();
    clr_mon();
    send_byte(8'h01);
    send_word(32'h0000_0020);
    send_word(32'h8C01_0004);
    send_word(32'hFFFF_FFFF);
    wait_idle(20, "load_basic");
    check_int("load_pc_clear_pulses", n_pcclr, 1);
    check_int("load_writes", n_wr, 3);
    check_int("load_addr0", int'(wr_addr[0]), 0);
    check_int("load_addr1", int'(wr_addr[1]), 1);
    check_int("load_addr2", int'(wr_addr[2]), 2);
    checks++;
    if (wr_data[0] !== 32'h0000_0020 || wr_data[1] !== 32'h8C01_0004 || wr_data[2] !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL load_data: got %h %h %h, expected 00000020 8c010004 ffffffff",
               wr_data[0], wr_data[1], wr_data[2]);
    end
    check_int("load_exclusive", n_excl, 0);
  endtask

  task automatic test_load_full();
    int bad;
    clr_mon();
    send_byte(8'h01);
    for (int i = 0; i < 128; i++) send_word(32'h1000_0000 + i);
    repeat (2) @(negedge clock);
    check_int("full_state_idle", int'(state_o), 0);
    check_int("full_writes", n_wr, 128);
    bad = 0;
    for (int i = 0; i < 128; i++)
      if (wr_addr[i] !== i[6:0] || wr_data[i] !== (32'h1000_0000 + i)) bad++;
    check_int("full_addr_data_errors", bad, 0);
    send_byte(8'h02);
    check_int("full_next_is_run", int'(state_o), 3);
    check_int("full_no_pc_clear_after", n_pcclr, 1);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_step();
    clr_mon();
    pc_i = 7'd5;
    send_byte(8'h03);
    wait_idle(3000, "step");
    check_int("step_en_cycles", n_en, 1);
    check_dump("step", 8'h05);
  endtask

  task automatic test_run();
    clr_mon();
    pc_i = 7'd42;
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h03);
    repeat (16) @(negedge clock);
    checks++;
    if (en_pipeline !== 1'b1 || state_o !== 3'd3) begin
      failures++;
      $display("FAIL run_active: en=%b state=%0d, expected en=1 state=3", en_pipeline, state_o);
    end
    halt_i = 1'b1;
    @(negedge clock);
    halt_i = 1'b0;
    checks++;
    if (en_pipeline !== 1'b0 || state_o !== 3'd5) begin
      failures++;
      $display("FAIL run_halt_edge: en=%b state=%0d, expected en=0 state=5", en_pipeline, state_o);
    end
    checks++;
    if (n_en < 20) begin
      failures++;
      $display("FAIL run_en_cycles: got %0d, expected at least 20", n_en);
    end
    wait_idle(3000, "run");
    check_int("run_rx_ignored_pc_clear", n_pcclr, 0);
    check_int("run_rx_ignored_writes", n_wr, 0);
    check_dump("run", 8'd42);
  endtask

  task automatic test_ignore();
    clr_mon();
    send_byte(8'h7A);
    repeat (5) @(negedge clock);
    check_int("ignore_busy", int'(busy), 0);
    check_int("ignore_state", int'(state_o), 0);
    check_int("ignore_activity", n_pcclr + n_wr + n_en + tx_q.size(), 0);
  endtask

  task automatic test_reset_abort();
    clr_mon();
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clock); rx_data = 8'h33; rx_done = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (outs !== 60'd0) begin
      failures++;
      $display("FAIL abort_load_outputs: got %h, expected 0", outs);
    end
    rx_done = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    clr_mon();
    send_byte(8'h01);
    send_word(32'hAABB_CCDD);
    send_word(32'hFFFF_FFFF);
    wait_idle(20, "abort_reload");
    check_int("abort_reload_writes", n_wr, 2);
    check_int("abort_reload_addr0", int'(wr_addr[0]), 0);
    checks++;
    if (wr_data[0] !== 32'hAABB_CCDD) begin
      failures++;
      $display("FAIL abort_reload_data0: got %h, expected aabbccdd", wr_data[0]);
    end

    clr_mon();
    pc_i = 7'd9;
    send_byte(8'h03);
    repeat (100) @(negedge clock);
    checks++;
    if (busy !== 1'b1 || tx_q.size() == 0) begin
      failures++;
      $display("FAIL abort_dump_active: busy=%b bytes=%0d, expected busy=1 bytes>0", busy, tx_q.size());
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (outs !== 60'd0) begin
      failures++;
      $display("FAIL abort_dump_outputs: got %h, expected 0", outs);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    clr_mon();
    send_byte(8'h01);
    send_word(32'hFFFF_FFFF);
    wait_idle(20, "abort_dump_reload");
    check_int("abort_dump_reload_writes", n_wr, 1);
    check_int("abort_dump_reload_addr0", int'(wr_addr[0]), 0);
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_load_basic();
    test_load_full();
    test_step();
    test_run();
    test_ignore();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
